// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the pipelined MIPS control unit: the per-stage
// control bundle, opcode/funct encodings, ALU op codes and the sequencing FSM states.
package cpu_ctrl_pkg;

  // Field width of ctrl_t.dst; the unit's REG_W parameter is expected to match it.
  localparam int CTRL_REG_W = 5;

  typedef struct packed {
    logic                  valid;
    logic                  jump;
    logic                  branch;
    logic                  branch_ne;
    logic                  reg_dst;
    logic                  reg_write;
    logic                  alu_src;
    logic [2:0]            alu_op;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  jr;
    logic                  link;
    logic                  finish;
    logic [CTRL_REG_W-1:0] dst;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL     = 6'b000000;
  localparam logic [5:0] FN_SRL     = 6'b000010;
  localparam logic [5:0] FN_SRA     = 6'b000011;
  localparam logic [5:0] FN_SLLV    = 6'b000100;
  localparam logic [5:0] FN_SRLV    = 6'b000110;
  localparam logic [5:0] FN_SRAV    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_SUBU    = 6'b100011;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_XOR     = 6'b100110;
  localparam logic [5:0] FN_NOR     = 6'b100111;
  localparam logic [5:0] FN_SLT     = 6'b101010;
  localparam logic [5:0] FN_SLTU    = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_R   = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_LUI = 3'b101;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } ctrl_state_t;

  // R-type functs that go to the ALU (jr and syscall are handled separately).
  function automatic logic is_rtype_alu(input logic [5:0] fn);
    case (fn)
      FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: is_rtype_alu = 1'b1;
      default:                                        is_rtype_alu = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID-stage decoder: opcode/funct/register fields to a control bundle,
// plus the illegal-instruction flag and whether the instruction reads rt.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int LINK_REG = 31
) (
  input  logic [5:0]       op_i,
  input  logic [5:0]       funct_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic [REG_W-1:0] rd_i,
  output ctrl_t            ctl_o,
  output logic             illegal_o,
  output logic             uses_rt_o
);

  always_comb begin
    ctl_o     = CTRL_BUBBLE;
    illegal_o = 1'b0;
    uses_rt_o = 1'b0;

    case (op_i)
      OP_RTYPE: begin
        uses_rt_o = 1'b1;
        if (funct_i == FN_JR) begin
          ctl_o.jr = 1'b1;
        end else if (funct_i == FN_SYSCALL) begin
          ctl_o.finish = 1'b1;
        end else if (is_rtype_alu(funct_i)) begin
          ctl_o.reg_dst   = 1'b1;
          ctl_o.reg_write = 1'b1;
          ctl_o.alu_op    = ALU_R;
        end else begin
          illegal_o = 1'b1;
        end
      end
      OP_ADDI: begin
        ctl_o.alu_src   = 1'b1;
        ctl_o.reg_write = 1'b1;
        ctl_o.alu_op    = ALU_ADD;
      end
      OP_ANDI: begin
        ctl_o.alu_src   = 1'b1;
        ctl_o.reg_write = 1'b1;
        ctl_o.alu_op    = ALU_AND;
      end
      OP_ORI: begin
        ctl_o.alu_src   = 1'b1;
        ctl_o.reg_write = 1'b1;
        ctl_o.alu_op    = ALU_OR;
      end
      OP_LUI: begin
        ctl_o.alu_src   = 1'b1;
        ctl_o.reg_write = 1'b1;
        ctl_o.alu_op    = ALU_LUI;
      end
      OP_LW: begin
        ctl_o.alu_src    = 1'b1;
        ctl_o.mem_read   = 1'b1;
        ctl_o.mem_to_reg = 1'b1;
        ctl_o.reg_write  = 1'b1;
      end
      OP_SW: begin
        uses_rt_o       = 1'b1;
        ctl_o.alu_src   = 1'b1;
        ctl_o.mem_write = 1'b1;
      end
      OP_BEQ: begin
        uses_rt_o    = 1'b1;
        ctl_o.branch = 1'b1;
        ctl_o.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        uses_rt_o       = 1'b1;
        ctl_o.branch    = 1'b1;
        ctl_o.branch_ne = 1'b1;
        ctl_o.alu_op    = ALU_SUB;
      end
      OP_J: begin
        ctl_o.jump = 1'b1;
      end
      OP_JAL: begin
        ctl_o.jump      = 1'b1;
        ctl_o.link      = 1'b1;
        ctl_o.reg_write = 1'b1;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase

    // An illegal instruction leaves the all-zero bundle, so valid stays low too.
    ctl_o.valid = !illegal_o;

    if (ctl_o.link) begin
      ctl_o.dst = REG_W'(LINK_REG);
    end else if (ctl_o.reg_dst) begin
      ctl_o.dst = rd_i;
    end else begin
      ctl_o.dst = rt_i;
    end
    // A zero dst on non-writers keeps the hazard compare from matching stale fields.
    if (!ctl_o.reg_write) begin
      ctl_o.dst = '0;
    end
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined MIPS control unit: decodes ID, carries bundles through STAGES stage
// registers, handles load-use stall, branch flush and the syscall drain-and-halt FSM.
module ctrl_pipe_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int STAGES   = 3,
  parameter int REG_W    = 5,
  parameter int LINK_REG = 31
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [5:0]               id_op,
  input  logic [5:0]               id_funct,
  input  logic [REG_W-1:0]         id_rs,
  input  logic [REG_W-1:0]         id_rt,
  input  logic [REG_W-1:0]         id_rd,
  input  logic                     br_taken,
  output ctrl_t [STAGES-1:0]       stage_ctl,
  output logic                     stall_out,
  output logic                     flush_out,
  output logic                     illegal_out,
  output logic                     halted
);

  localparam int CNT_W = $clog2(STAGES + 1);

  ctrl_t              dec_ctl;
  logic               dec_illegal;
  logic               dec_uses_rt;

  ctrl_t [STAGES-1:0] stage_q, stage_d;
  ctrl_state_t        state_q, state_d;
  logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;

  logic               hazard;
  logic               accept;

  ctrl_decode #(
    .REG_W    (REG_W),
    .LINK_REG (LINK_REG)
  ) u_decode (
    .op_i      (id_op),
    .funct_i   (id_funct),
    .rt_i      (id_rt),
    .rd_i      (id_rd),
    .ctl_o     (dec_ctl),
    .illegal_o (dec_illegal),
    .uses_rt_o (dec_uses_rt)
  );

  // ---- ID / EX boundary: load-use detection against the bundle now in EX ----
  always_comb begin
    hazard = stage_q[0].valid && stage_q[0].mem_read && (stage_q[0].dst != '0) &&
             id_valid &&
             ((stage_q[0].dst == id_rs) || (dec_uses_rt && (stage_q[0].dst == id_rt)));
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    stall_out   = 1'b0;
    flush_out   = 1'b0;
    accept      = 1'b0;

    if (!rst) begin
      case (state_q)
        RUN: begin
          // Branch flush takes priority over both the load-use stall and syscall.
          if (br_taken) begin
            flush_out = 1'b1;
          end else if (hazard) begin
            stall_out = 1'b1;
          end else if (id_valid) begin
            accept = 1'b1;
            if (dec_ctl.finish) begin
              state_d     = DRAIN;
              drain_cnt_d = CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          stall_out   = 1'b1;
          drain_cnt_d = drain_cnt_q + 1'b1;
          if (drain_cnt_q == CNT_W'(STAGES)) begin
            state_d     = HALT;
            drain_cnt_d = drain_cnt_q;
          end
        end
        HALT: begin
          stall_out = 1'b1;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_comb begin
    stage_d    = '0;
    stage_d[0] = accept ? dec_ctl : CTRL_BUBBLE;
    for (int k = 1; k < STAGES; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // ---- stage register boundary: EX .. WB advance every edge ----
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q     <= '0;
      state_q     <= RUN;
      drain_cnt_q <= '0;
    end else begin
      stage_q     <= stage_d;
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign stage_ctl   = stage_q;
  assign illegal_out = accept && dec_illegal;
  assign halted      = (state_q == HALT);

endmodule
